hazard_detection_unit: RTL and testbench
========================================

# hazard_detection_unit

Load-use hazard detector for the 5-stage RV32I pipeline. It sits in the decode stage. It compares the source registers of the instruction in IF/ID against the destination of a load in ID/EX. On a match it freezes the PC and the IF/ID register and steers the control mux so that a bubble enters ID/EX. The stall decision is purely combinational. A small clocked block keeps stall statistics for debug and performance counting.

## Interface
Parameters:
- CNT_W, default 32: width of the stall event counter.

Ports:
- clk  in  1  pipeline clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high; clears the statistics state only.
- IFID_Reg_Rs  in  5  rs1 field of the instruction in IF/ID.
- IFID_Reg_Rd  in  5  second compared source field of the IF/ID instruction (rs2 position).
- IDEX_MemRead  in  1  the instruction in ID/EX is a load.
- IDEX_Reg_Rd  in  5  rd of the instruction in ID/EX.
- PC_write  out  1  1 = PC may update; 0 = hold PC.
- IFID_write  out  1  1 = IF/ID may load; 0 = hold IF/ID.
- Mux_select  out  1  1 = zero all control signals into ID/EX (bubble); 0 = pass decoded control.
- stall_active_q  out  1  registered copy of the previous cycle's stall decision.
- stall_count  out  CNT_W  number of stall cycles since reset; saturating.

## Operation
- hazard = IDEX_MemRead & ((IDEX_Reg_Rd == IFID_Reg_Rs) | (IDEX_Reg_Rd == IFID_Reg_Rd)).
- Register x0 is NOT exempt. A load to x0 followed by a use of x0 still stalls. This gives a conservative, simple comparator.
- When hazard = 1: PC_write=0, IFID_write=0, Mux_select=1.
- When hazard = 0: PC_write=1, IFID_write=1, Mux_select=0.
- PC_write and IFID_write are always the complement of Mux_select.
- Non-load instructions in ID/EX (IDEX_MemRead=0) never cause a stall, regardless of register matches.
- Statistics:
  - stall_active_q <= hazard each cycle.
  - stall_count increments by 1 in each cycle where hazard = 1.
  - stall_count holds at all-ones and never wraps.

## Timing
- Stall outputs are zero-latency combinational functions of the current inputs.
- Stall outputs are valid without any clock edge or reset, including at time 0.
- There is no registered element on the stall path.
- The stall lasts exactly one cycle in normal operation. The bubble clears IDEX_MemRead in the next cycle, so hazard falls.
- reset affects only stall_active_q and stall_count; both are 0 after the first rising edge with reset=1.
- If reset and hazard are asserted in the same cycle, reset wins for the state. The combinational outputs still reflect the hazard.
- Reset asserted mid-stall does not alter PC_write, IFID_write or Mux_select.

## Structure
- The shared package or defines file supplies REG_ADDR_W = 5. Both the register fields and the x0 constant (if used elsewhere) come from there.
- One natural sub-module: hdu_reg_match. It is a 5-bit equality comparator, instantiated twice (rs1 and rs2 comparisons).
- The statistics counter is inline in this block.

## Test plan
- IDEX_Reg_Rd=0, IFID_Reg_Rs=0, IFID_Reg_Rd=0, IDEX_MemRead=1, with no clock or reset applied -> PC_write=0, IFID_write=0, Mux_select=1.
- IDEX_Reg_Rd=5'h1F, IFID_Reg_Rs=5'h1F, IFID_Reg_Rd=5'h1B, IDEX_MemRead=1 -> stall: PC_write=0, IFID_write=0, Mux_select=1.
- IDEX_Reg_Rd=5'h0A, IFID_Reg_Rs=5'h03, IFID_Reg_Rd=5'h0A, IDEX_MemRead=1 -> stall via the second field.
- IDEX_Reg_Rd=5'h1F, IFID_Reg_Rs=5'h1F, IFID_Reg_Rd=5'h1F, IDEX_MemRead=0 -> no stall: PC_write=1, IFID_write=1, Mux_select=0.
- IDEX_Reg_Rd=5'h04, IFID_Reg_Rs=5'h05, IFID_Reg_Rd=5'h06, IDEX_MemRead=1 -> no stall.
- Reset for one cycle, then hold a hazard for 3 clocks -> stall_count=3 and stall_active_q=1. Then reset for one cycle -> stall_count=0 and stall_active_q=0, while Mux_select stays 1.

Source files
------------

// File: rtl/hazard_detection_unit_pkg.sv
`default_nettype none
// ============================================================================
// Module      : hazard_detection_unit_pkg
// Description : Shared definitions for the load-use hazard detector.
//               REG_ADDR_W  - width of an RV32I register address field.
//               reg_addr_t  - register address type.
//               C_REG_X0    - address of the hard-wired zero register.
// Revision    : 1.0 - initial release
// ============================================================================
package hazard_detection_unit_pkg;

    localparam int REG_ADDR_W = 5;

    typedef logic [REG_ADDR_W-1:0] reg_addr_t;

    // x0 is deliberately not exempted by the hazard comparator; the constant
    // is kept here so other decode-stage blocks share one definition.
    localparam reg_addr_t C_REG_X0 = '0;

endpackage : hazard_detection_unit_pkg
`default_nettype wire

// File: rtl/hazard_detection_unit_reg_match.sv
`default_nettype none
// ============================================================================
// Module      : hdu_reg_match
// Description : Register-address equality comparator.
//   i_a, i_b  in  REG_ADDR_W  register addresses to compare
//   o_match   out 1           1 when i_a == i_b (x0 included)
// Revision    : 1.0 - initial release
// ============================================================================
module hdu_reg_match
    import hazard_detection_unit_pkg::*;
(
    input  reg_addr_t i_a,
    input  reg_addr_t i_b,
    output logic      o_match
);

    assign o_match = (i_a == i_b);

endmodule : hdu_reg_match
`default_nettype wire

// File: rtl/hazard_detection_unit.sv
`default_nettype none
// ============================================================================
// Module      : hazard_detection_unit
// Description : Decode-stage load-use hazard detector for the 5-stage RV32I
//               pipeline, with stall statistics for debug/performance.
//   clk             in   1      pipeline clock
//   reset           in   1      sync active-high; clears statistics only
//   IFID_Reg_Rs     in   5      rs1 of the IF/ID instruction
//   IFID_Reg_Rd     in   5      rs2-position field of the IF/ID instruction
//   IDEX_MemRead    in   1      ID/EX instruction is a load
//   IDEX_Reg_Rd     in   5      rd of the ID/EX instruction
//   PC_write        out  1      1 = PC may update
//   IFID_write      out  1      1 = IF/ID may load
//   Mux_select      out  1      1 = inject bubble into ID/EX
//   stall_active_q  out  1      previous cycle's stall decision
//   stall_count     out  CNT_W  saturating count of stall cycles
// Revision    : 1.0 - initial release
// ============================================================================
module hazard_detection_unit
    import hazard_detection_unit_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [4:0]       IFID_Reg_Rs,
    input  logic [4:0]       IFID_Reg_Rd,
    input  logic             IDEX_MemRead,
    input  logic [4:0]       IDEX_Reg_Rd,
    output logic             PC_write,
    output logic             IFID_write,
    output logic             Mux_select,
    output logic             stall_active_q,
    output logic [CNT_W-1:0] stall_count
);

    localparam logic [CNT_W-1:0] C_CNT_MAX = '1;
    localparam logic [CNT_W-1:0] C_CNT_ONE = CNT_W'(1);

    logic w_match_rs1;
    logic w_match_rs2;
    logic w_hazard;

    logic             r_stall_active;
    logic [CNT_W-1:0] r_stall_count;

    hdu_reg_match u_match_rs1 (
        .i_a     (IDEX_Reg_Rd),
        .i_b     (IFID_Reg_Rs),
        .o_match (w_match_rs1)
    );

    hdu_reg_match u_match_rs2 (
        .i_a     (IDEX_Reg_Rd),
        .i_b     (IFID_Reg_Rd),
        .o_match (w_match_rs2)
    );

    // Purely combinational stall path: valid from time 0 and independent of
    // reset, so a reset landing mid-stall never releases a held pipeline.
    assign w_hazard   = IDEX_MemRead & (w_match_rs1 | w_match_rs2);
    assign Mux_select = w_hazard;
    assign PC_write   = ~w_hazard;
    assign IFID_write = ~w_hazard;

    // Statistics; reset takes priority over a same-cycle hazard.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_stall_active <= 1'b0;
            r_stall_count  <= '0;
        end else begin
            r_stall_active <= w_hazard;
            // Saturate at all-ones rather than wrap.
            if (w_hazard && (r_stall_count != C_CNT_MAX)) begin
                r_stall_count <= r_stall_count + C_CNT_ONE;
            end
        end
    end

    assign stall_active_q = r_stall_active;
    assign stall_count    = r_stall_count;

endmodule : hazard_detection_unit
`default_nettype wire

// File: tb/tb_hazard_detection_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_hazard_detection_unit
// Description : Scoreboard bench for hazard_detection_unit. Stimulus pushes
//               hand-computed expectations; a monitor pops and compares.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_hazard_detection_unit;

    localparam int CNT_W = 3;   // small so saturation is reachable

    typedef struct {
        string            name;
        logic             pcw;
        logic             ifw;
        logic             mux;
        bit               chk_stats;
        logic             act;
        logic [CNT_W-1:0] cnt;
    } exp_t;

    logic             clk    = 1'b0;
    logic             clk_en = 1'b0;
    logic             reset  = 1'b0;
    logic [4:0]       ifid_rs  = '0;
    logic [4:0]       ifid_rd  = '0;
    logic             idex_mr  = 1'b0;
    logic [4:0]       idex_rd  = '0;
    logic             pc_write;
    logic             ifid_write;
    logic             mux_select;
    logic             stall_active_q;
    logic [CNT_W-1:0] stall_count;

    int checks = 0;
    int errors = 0;

    exp_t exp_q[$];
    event sample_ev;

    hazard_detection_unit #(.CNT_W(CNT_W)) dut (
        .clk            (clk),
        .reset          (reset),
        .IFID_Reg_Rs    (ifid_rs),
        .IFID_Reg_Rd    (ifid_rd),
        .IDEX_MemRead   (idex_mr),
        .IDEX_Reg_Rd    (idex_rd),
        .PC_write       (pc_write),
        .IFID_write     (ifid_write),
        .Mux_select     (mux_select),
        .stall_active_q (stall_active_q),
        .stall_count    (stall_count)
    );

    always begin
        #5;
        if (clk_en) clk = ~clk;
    end

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    // Monitor: pops every pending expectation whenever a sample is presented.
    initial begin
        exp_t e;
        forever begin
            @(sample_ev);
            while (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                cmp({e.name, ".PC_write"},   32'(pc_write),   32'(e.pcw));
                cmp({e.name, ".IFID_write"}, 32'(ifid_write), 32'(e.ifw));
                cmp({e.name, ".Mux_select"}, 32'(mux_select), 32'(e.mux));
                if (e.chk_stats) begin
                    cmp({e.name, ".stall_active_q"}, 32'(stall_active_q), 32'(e.act));
                    cmp({e.name, ".stall_count"},    32'(stall_count),    32'(e.cnt));
                end
            end
        end
    end

    task automatic drive(input logic [4:0] rd_ex, input logic [4:0] rs, input logic [4:0] rd_id,
                         input logic mr);
        idex_rd = rd_ex;
        ifid_rs = rs;
        ifid_rd = rd_id;
        idex_mr = mr;
    endtask

    // hz is the hand-derived stall decision for the vector currently applied.
    task automatic expect_now(input string name, input logic hz, input bit chk,
                              input logic act, input logic [CNT_W-1:0] cnt);
        exp_t e;
        e.name = name;
        e.pcw  = ~hz;
        e.ifw  = ~hz;
        e.mux  = hz;
        e.chk_stats = chk;
        e.act  = act;
        e.cnt  = cnt;
        #1;
        exp_q.push_back(e);
        -> sample_ev;
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, expected finish");
        $fatal(1);
    end

    initial begin
        // Combinational vectors, no clock and no reset yet.
        drive(5'h00, 5'h00, 5'h00, 1'b1); expect_now("x0_load_use", 1'b1, 0, 1'b0, '0);
        drive(5'h1F, 5'h1F, 5'h1B, 1'b1); expect_now("rs1_match",   1'b1, 0, 1'b0, '0);
        drive(5'h0A, 5'h03, 5'h0A, 1'b1); expect_now("rs2_match",   1'b1, 0, 1'b0, '0);
        drive(5'h1F, 5'h1F, 5'h1F, 1'b0); expect_now("not_load",    1'b0, 0, 1'b0, '0);
        drive(5'h04, 5'h05, 5'h06, 1'b1); expect_now("no_match",    1'b0, 0, 1'b0, '0);
        drive(5'h11, 5'h11, 5'h11, 1'b1); expect_now("both_match",  1'b1, 0, 1'b0, '0);

        // Clocked statistics.
        clk_en = 1'b1;
        @(negedge clk);
        reset = 1'b1;
        drive(5'h04, 5'h05, 5'h06, 1'b1);
        @(negedge clk);
        expect_now("after_reset", 1'b0, 1, 1'b0, 3'd0);

        reset = 1'b0;
        drive(5'h1F, 5'h1F, 5'h1B, 1'b1);
        repeat (3) @(negedge clk);
        expect_now("three_stalls", 1'b1, 1, 1'b1, 3'd3);

        reset = 1'b1;               // hazard still asserted
        @(negedge clk);
        expect_now("reset_mid_stall", 1'b1, 1, 1'b0, 3'd0);

        reset = 1'b0;
        @(negedge clk);
        expect_now("stall_after_reset", 1'b1, 1, 1'b1, 3'd1);

        repeat (7) @(negedge clk);  // 8 stall cycles total, counter maxes at 7
        expect_now("saturate", 1'b1, 1, 1'b1, 3'd7);

        drive(5'h1F, 5'h1F, 5'h1B, 1'b0);   // bubble has cleared MemRead
        @(negedge clk);
        expect_now("bubble_clears", 1'b0, 1, 1'b0, 3'd7);

        #2;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: %0d left, expected 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_hazard_detection_unit
`default_nettype wire
